// File: rtl/menu_ctl.sv
// Menu controller: selects one or two players from the key inputs, starts a
// race on enter and returns to the menu once the race ends and enter is released.
// Key presses are edge-detected after synchronisation. After each accepted
// press, further presses are locked out for a number of frames.
module menu_ctl #(
    parameter int LOCK_FRAMES = 8
) (
    input  logic pclk,
    input  logic rst,
    input  logic key_up,
    input  logic key_down,
    input  logic key_enter,
    input  logic vsync_in,
    input  logic game_over,
    output logic playerCount,
    output logic game_start,
    output logic menu_active
);

    typedef enum logic [1:0] {
        MENU     = 2'd0,
        START    = 2'd1,
        PLAY     = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_LOAD = 4'(LOCK_FRAMES);

    // Bit order of the synchroniser vectors: {vsync, enter, down, up}
    logic [3:0] sync1_q, sync2_q, prev_q;
    logic [3:0] press;
    logic       up_ev, down_ev, enter_ev, tick, enter_lvl;

    state_t     state_q, state_d;
    logic       pc_q, pc_d;
    logic [3:0] lock_q, lock_d;
    logic       gs_q, gs_d;
    logic       ma_q, ma_d;

    // Two-flop synchroniser plus a previous-value flop for rising-edge detection
    always_ff @(posedge pclk) begin
        if (rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            prev_q  <= 4'b0000;
        end else begin
            sync1_q <= {vsync_in, key_enter, key_down, key_up};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press     = sync2_q & ~prev_q;
    assign up_ev     = press[0];
    assign down_ev   = press[1];
    assign enter_ev  = press[2];
    assign tick      = press[3];
    assign enter_lvl = sync2_q[2];

    // Next state, player selection and lockout counter
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lock_d  = lock_q;

        if ((lock_q != 4'd0) && tick) begin
            lock_d = lock_q - 4'd1;
        end

        case (state_q)
            MENU: begin
                if (lock_q == 4'd0) begin
                    // Enter wins over a simultaneous up/down; up and down
                    // together cancel out and do not load the lockout.
                    if (enter_ev) begin
                        state_d = START;
                        lock_d  = LOCK_LOAD;
                    end else if (up_ev ^ down_ev) begin
                        pc_d   = down_ev;
                        lock_d = LOCK_LOAD;
                    end
                end
            end
            START: begin
                state_d = PLAY;
            end
            PLAY: begin
                if (game_over) begin
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                // Hold here until enter is let go so a held key cannot restart
                if (!enter_lvl) begin
                    state_d = MENU;
                end
            end
            default: begin
                state_d = MENU;
            end
        endcase

        gs_d = (state_d == START);
        ma_d = (state_d == MENU);
    end

    // Control state and registered outputs
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= MENU;
            pc_q    <= 1'b0;
            lock_q  <= 4'd0;
            gs_q    <= 1'b0;
            ma_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lock_q  <= lock_d;
            gs_q    <= gs_d;
            ma_q    <= ma_d;
        end
    end

    assign playerCount = pc_q;
    assign game_start  = gs_q;
    assign menu_active = ma_q;

endmodule

// File: doc/menu_ctl.md
MENU_CTL -- requirements
Module: menu_ctl

Interface
REQ-001 The block SHALL have parameter LOCK_FRAMES, default 8, giving the number of frames during which new key presses are ignored after an accepted press (range 1..15).
REQ-002 The block SHALL have port pclk, input, 1 bit: the single clock; all logic rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port key_up, input, 1 bit: level, high while the up key is held; asynchronous to pclk.
REQ-005 The block SHALL have port key_down, input, 1 bit: level, high while the down key is held; asynchronous to pclk.
REQ-006 The block SHALL have port key_enter, input, 1 bit: level, high while the enter key is held; asynchronous to pclk.
REQ-007 The block SHALL have port vsync_in, input, 1 bit: VGA vertical sync from the timing chain, used as the frame tick.
REQ-008 The block SHALL have port game_over, input, 1 bit: one-cycle pulse, synchronous to pclk, marking the end of a race.
REQ-009 The block SHALL have port playerCount, output, 1 bit: selected menu entry (0 = one player, 1 = two players); it feeds the menu text highlight stage.
REQ-010 The block SHALL have port game_start, output, 1 bit: one-cycle pulse when a race starts.
REQ-011 The block SHALL have port menu_active, output, 1 bit: high while the menu screen is shown.

Function
REQ-012 key_up, key_down, key_enter and vsync_in SHALL each pass through a 2-flop synchronizer followed by a third "previous" flop.
REQ-013 A press event SHALL be defined as synchronized level 1 and previous level 0, i.e. a rising edge only; held keys SHALL NOT repeat.
REQ-014 A frame tick SHALL be a rising edge of synchronized vsync_in.
REQ-015 The block SHALL implement states MENU, START, PLAY and WAIT_REL, encoded in a 2-bit register.
REQ-016 In MENU with no lockout active, an up event SHALL set playerCount to 0 and a down event SHALL set it to 1; values saturate, with no wrap-around.
REQ-017 If up and down events occur in the same cycle, both SHALL be ignored and playerCount SHALL be unchanged.
REQ-018 In MENU with no lockout active, an enter event SHALL move the FSM to START; a simultaneous up or down event SHALL be ignored, since enter has priority.
REQ-019 Every accepted up, down or enter event SHALL load the lockout counter with LOCK_FRAMES.
REQ-020 While the lockout counter is nonzero, it SHALL decrement on each frame tick, and all key events SHALL be ignored.
REQ-021 If a frame tick coincides with an accepted event, the load SHALL win over the decrement.
REQ-022 START SHALL last exactly one cycle, with game_start = 1, and SHALL then go to PLAY.
REQ-023 In PLAY, all key events SHALL be ignored and playerCount SHALL be frozen.
REQ-024 In PLAY, game_over = 1 SHALL move the FSM to WAIT_REL.
REQ-025 game_over SHALL be ignored in MENU, START and WAIT_REL.
REQ-026 WAIT_REL SHALL stay until the synchronized key_enter is 0, then go to MENU; this prevents an immediate restart.
REQ-027 On entry to MENU from WAIT_REL, playerCount SHALL retain its last value.
REQ-028 menu_active SHALL be 1 exactly when the state is MENU.
REQ-029 game_start SHALL be 1 exactly when the state is START.
REQ-030 All outputs SHALL be driven from registers.
REQ-031 Latency: a key asserted before rising edge k SHALL take effect on outputs at edge k+2, i.e. visible after the third rising edge.

Reset
REQ-032 While rst = 1 at a rising edge, the block SHALL force state = MENU, playerCount = 0, game_start = 0, menu_active = 1, lockout counter = 0, and all synchronizer and previous flops = 0.
REQ-033 Reset asserted in any state, including START and PLAY, SHALL override every other event in that cycle.
REQ-034 After reset, a key already held high SHALL produce one press event, because the previous flops are 0.

Verification
REQ-035 The bench SHALL check: reset, then key_down pulse held 5 cycles -> playerCount 0->1 on the 3rd edge after assertion; a second down within 8 frames -> no change; up after 8 vsync ticks -> playerCount = 0.
REQ-036 The bench SHALL check: key_up and key_down rise in the same cycle in MENU -> playerCount unchanged, and no lockout loaded (an up 1 frame later is accepted).
REQ-037 The bench SHALL check: enter with playerCount = 1 -> game_start high for exactly 1 cycle, menu_active 0; up/down presses in PLAY -> playerCount stays 1.
REQ-038 The bench SHALL check: game_over pulse in PLAY while key_enter is held -> state stays WAIT_REL, menu_active 0; releasing enter -> menu_active 1 three edges later, with no game_start.
REQ-039 The bench SHALL check: rst asserted in the START cycle -> next cycle game_start = 0, menu_active = 1, playerCount = 0.
REQ-040 The bench SHALL check: game_over pulse in MENU -> no state change.
